// File: rtl/hwag_pkg.sv
// Shared types and constants for the HWAG ignition coil scheduler.
// Angles are modular over 0..ACNT_TOP; all schedule events are equality matches.
package hwag_pkg;

  localparam int ANGLE_W = 24;

  typedef logic [ANGLE_W-1:0] angle_t;

  localparam angle_t ACNT_TOP = 24'd3839;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHARGE = 2'd1,
    FIRED  = 2'd2
  } coil_state_t;

endpackage

// File: rtl/hwag_coil_channel.sv
// One coil channel: pending/active angle registers, safe-point commit,
// charge/ignite FSM and the dwell-limit watchdog with its sticky fault flag.
module hwag_coil_channel
  import hwag_pkg::*;
#(
  parameter int AW = 24,
  parameter int DW = 24
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          hwag_start_i,
  input  logic          acnt_ena_i,
  input  logic [AW-1:0] acnt_i,
  input  logic          wr_i,
  input  logic [AW-1:0] wr_charge_i,
  input  logic [AW-1:0] wr_ignite_i,
  input  logic [DW-1:0] max_dwell_i,
  input  logic          fault_clr_i,
  output logic          coil_o,
  output logic          fault_o
);

  coil_state_t   state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [AW-1:0] act_c_q, act_c_d, act_i_q, act_i_d;
  logic [AW-1:0] pend_c_q, pend_c_d, pend_i_q, pend_i_d;
  logic          pend_v_q, pend_v_d;
  logic          fault_q, fault_d;
  logic          coil_q, coil_d;

  logic win_ok, ch_hit, ig_hit, tmo, fault_set, commit;

  // A degenerate window (charge == ignite, e.g. after reset) never matches.
  assign win_ok = (act_c_q != act_i_q);
  assign ch_hit = acnt_ena_i && (acnt_i == act_c_q) && win_ok;
  assign ig_hit = acnt_ena_i && (acnt_i == act_i_q) && win_ok;
  assign tmo    = (max_dwell_i != '0) && (dwell_q == max_dwell_i - DW'(1));

  always_comb begin
    state_d   = state_q;
    dwell_d   = dwell_q;
    fault_set = 1'b0;
    if (!hwag_start_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ch_hit) begin
            state_d = CHARGE;
            dwell_d = '0;
          end
        end
        CHARGE: begin
          if (dwell_q != '1) dwell_d = dwell_q + DW'(1);
          if (ig_hit) begin
            state_d = IDLE;
          end else if (tmo) begin
            state_d   = FIRED;
            fault_set = 1'b1;
          end
        end
        FIRED: begin
          if (ig_hit) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Angles move only while idle and not about to start charging, so a
  // running dwell window always closes on the angle it opened with.
  assign commit = (state_q == IDLE) && !(hwag_start_i && ch_hit) && pend_v_q;

  always_comb begin
    act_c_d  = act_c_q;
    act_i_d  = act_i_q;
    pend_c_d = pend_c_q;
    pend_i_d = pend_i_q;
    pend_v_d = pend_v_q;
    if (commit) begin
      act_c_d  = pend_c_q;
      act_i_d  = pend_i_q;
      pend_v_d = 1'b0;
    end
    if (wr_i) begin
      pend_c_d = wr_charge_i;
      pend_i_d = wr_ignite_i;
      pend_v_d = 1'b1;
    end
  end

  assign fault_d = (fault_q & ~fault_clr_i) | fault_set;
  assign coil_d  = (state_d == CHARGE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      dwell_q  <= '0;
      act_c_q  <= '0;
      act_i_q  <= '0;
      pend_c_q <= '0;
      pend_i_q <= '0;
      pend_v_q <= 1'b0;
      fault_q  <= 1'b0;
      coil_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      act_c_q  <= act_c_d;
      act_i_q  <= act_i_d;
      pend_c_q <= pend_c_d;
      pend_i_q <= pend_i_d;
      pend_v_q <= pend_v_d;
      fault_q  <= fault_d;
      coil_q   <= coil_d;
    end
  end

  assign coil_o  = coil_q;
  assign fault_o = fault_q;

endmodule

// File: rtl/hwag_coil_sched.sv
// Coil scheduler top: validates CPU angle writes, returns ack/err, and
// fans the accepted write and fault clears out to the per-channel sequencers.
module hwag_coil_sched
  import hwag_pkg::*;
#(
  parameter int CH = 4,
  parameter int AW = 24,
  parameter int DW = 24
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  hwag_start_i,
  input  logic                  acnt_ena_i,
  input  logic [AW-1:0]         acnt_i,
  input  logic                  cfg_we_i,
  input  logic [$clog2(CH)-1:0] cfg_ch_i,
  input  logic [AW-1:0]         cfg_charge_i,
  input  logic [AW-1:0]         cfg_ignite_i,
  output logic                  cfg_ack_o,
  output logic                  cfg_err_o,
  input  logic [DW-1:0]         max_dwell_i,
  output logic [CH-1:0]         coil_out_o,
  output logic [CH-1:0]         ch_fault_o,
  input  logic [CH-1:0]         fault_clr_i
);

  logic          cfg_ok;
  logic          ack_q, ack_d, err_q, err_d;
  logic [CH-1:0] wr_q, wr_d;
  logic [AW-1:0] wr_c_q, wr_c_d, wr_i_q, wr_i_d;

  assign cfg_ok = (cfg_charge_i <= AW'(ACNT_TOP)) && (cfg_ignite_i <= AW'(ACNT_TOP)) &&
                  (cfg_charge_i != cfg_ignite_i);

  // Writes are registered once here; the channel loads pending in the ack cycle.
  always_comb begin
    ack_d  = cfg_we_i && cfg_ok;
    err_d  = cfg_we_i && !cfg_ok;
    wr_d   = '0;
    wr_c_d = wr_c_q;
    wr_i_d = wr_i_q;
    if (cfg_we_i && cfg_ok) begin
      wr_d[cfg_ch_i] = 1'b1;
      wr_c_d         = cfg_charge_i;
      wr_i_d         = cfg_ignite_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      wr_q   <= '0;
      wr_c_q <= '0;
      wr_i_q <= '0;
    end else begin
      ack_q  <= ack_d;
      err_q  <= err_d;
      wr_q   <= wr_d;
      wr_c_q <= wr_c_d;
      wr_i_q <= wr_i_d;
    end
  end

  assign cfg_ack_o = ack_q;
  assign cfg_err_o = err_q;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    hwag_coil_channel #(
      .AW(AW),
      .DW(DW)
    ) u_ch (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .hwag_start_i(hwag_start_i),
      .acnt_ena_i  (acnt_ena_i),
      .acnt_i      (acnt_i),
      .wr_i        (wr_q[i]),
      .wr_charge_i (wr_c_q),
      .wr_ignite_i (wr_i_q),
      .max_dwell_i (max_dwell_i),
      .fault_clr_i (fault_clr_i[i]),
      .coil_o      (coil_out_o[i]),
      .fault_o     (ch_fault_o[i])
    );
  end

endmodule

// File: tb/tb_hwag_coil_sched.sv
// Self-checking bench for hwag_coil_sched: directed scenarios plus a randomized
// sweep, all compared against a rule-level behavioural model of the scheduler.
module tb_hwag_coil_sched;

  localparam int CH = 4;

  logic          clk, rst_n, hwag_start, acnt_ena, cfg_we, cfg_ack, cfg_err;
  logic [23:0]   acnt, cfg_charge, cfg_ignite, max_dwell;
  logic [1:0]    cfg_ch;
  logic [CH-1:0] coil_out, ch_fault, fault_clr;

  hwag_coil_sched #(.CH(CH), .AW(24), .DW(24)) dut (
    .clk_i(clk), .rst_ni(rst_n), .hwag_start_i(hwag_start), .acnt_ena_i(acnt_ena),
    .acnt_i(acnt), .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch), .cfg_charge_i(cfg_charge),
    .cfg_ignite_i(cfg_ignite), .cfg_ack_o(cfg_ack), .cfg_err_o(cfg_err),
    .max_dwell_i(max_dwell), .coil_out_o(coil_out), .ch_fault_o(ch_fault),
    .fault_clr_i(fault_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, tcyc = 0;

  // Model: mode 0 = off, 1 = charging, 2 = timed out waiting for ignite angle.
  int ma_c[CH], ma_i[CH], mp_c[CH], mp_i[CH], mmode[CH], mheld[CH];
  bit mp_v[CH], mfault[CH];
  bit mack, merr, wq_v;
  int wq_ch, wq_c, wq_i;

  // Scheduled write fired on a given strobe angle during a sweep.
  bit sw_en; int sw_at, sw_ch, sw_c, sw_i;
  int n_rise[CH], hi2;
  logic [CH-1:0] prev_coil;

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      ma_c[c] = 0; ma_i[c] = 0; mp_c[c] = 0; mp_i[c] = 0; mp_v[c] = 0;
      mmode[c] = 0; mheld[c] = 0; mfault[c] = 0;
    end
    mack = 0; merr = 0; wq_v = 0;
  endtask

  task automatic model_step();
    bit ok, chg, ign, fset;
    ok = (cfg_charge <= 3839) && (cfg_ignite <= 3839) && (cfg_charge != cfg_ignite);
    for (int c = 0; c < CH; c++) begin
      chg = acnt_ena && (int'(acnt) == ma_c[c]) && (ma_c[c] != ma_i[c]);
      ign = acnt_ena && (int'(acnt) == ma_i[c]) && (ma_c[c] != ma_i[c]);
      if (mmode[c] == 0 && !(hwag_start && chg) && mp_v[c]) begin
        ma_c[c] = mp_c[c]; ma_i[c] = mp_i[c]; mp_v[c] = 0;
      end
      if (wq_v && wq_ch == c) begin
        mp_c[c] = wq_c; mp_i[c] = wq_i; mp_v[c] = 1;
      end
      fset = 0;
      if (!hwag_start) mmode[c] = 0;
      else if (mmode[c] == 0) begin
        if (chg) begin mmode[c] = 1; mheld[c] = 0; end
      end else if (mmode[c] == 1) begin
        mheld[c]++;
        if (ign) mmode[c] = 0;
        else if (max_dwell != 0 && mheld[c] == int'(max_dwell)) begin
          mmode[c] = 2; fset = 1;
        end
      end else if (ign) mmode[c] = 0;
      if (fault_clr[c]) mfault[c] = 0;
      if (fset) mfault[c] = 1;
    end
    wq_v = cfg_we && ok; wq_ch = int'(cfg_ch); wq_c = int'(cfg_charge); wq_i = int'(cfg_ignite);
    mack = cfg_we && ok; merr = cfg_we && !ok;
  endtask

  function automatic logic [CH-1:0] exp_coil();
    logic [CH-1:0] r;
    for (int c = 0; c < CH; c++) r[c] = (mmode[c] == 1);
    return r;
  endfunction

  function automatic logic [CH-1:0] exp_fault();
    logic [CH-1:0] r;
    for (int c = 0; c < CH; c++) r[c] = mfault[c];
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    #1;
    tcyc++;
  endtask

  task automatic wr_cfg(input int ch, input int c, input int i);
    cfg_we = 1; cfg_ch = 2'(ch); cfg_charge = 24'(c); cfg_ignite = 24'(i);
    cyc();
    cfg_we = 0;
  endtask

  task automatic sweep(input int from, input int to, input int period, input bit rnd);
    int n, a, gap, tmp;
    n = ((to - from + 3840) % 3840) + 1;
    for (int s = 0; s < n; s++) begin
      a = (from + s) % 3840;
      acnt = 24'(a); acnt_ena = 1;
      if (sw_en && a == sw_at) begin
        cfg_we = 1; cfg_ch = 2'(sw_ch); cfg_charge = 24'(sw_c); cfg_ignite = 24'(sw_i);
        sw_en = 0;
      end
      if (rnd) begin
        if ($urandom_range(0, 15) == 0) begin
          cfg_we = 1; cfg_ch = 2'($urandom_range(0, 3));
          tmp = ($urandom_range(0, 19) == 0) ? 3840 + $urandom_range(0, 5)
                                             : (a + $urandom_range(3, 40)) % 3840;
          cfg_charge = 24'(tmp);
          tmp = ($urandom_range(0, 19) == 0) ? tmp : (tmp + $urandom_range(1, 60)) % 3840;
          cfg_ignite = 24'(tmp);
        end
        if ($urandom_range(0, 31) == 0) fault_clr = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 199) == 0) hwag_start = 0;
      end
      gap = rnd ? $urandom_range(1, 3) : period;
      for (int g = 0; g < gap; g++) begin
        cyc();
        n_cmp += 4;
        if (coil_out !== exp_coil()) begin
          n_bad++; $display("FAIL coil_out t=%0d acnt=%0d got %b exp %b", tcyc, a, coil_out, exp_coil());
        end
        if (ch_fault !== exp_fault()) begin
          n_bad++; $display("FAIL ch_fault t=%0d acnt=%0d got %b exp %b", tcyc, a, ch_fault, exp_fault());
        end
        if (cfg_ack !== mack) begin
          n_bad++; $display("FAIL cfg_ack t=%0d got %b exp %b", tcyc, cfg_ack, mack);
        end
        if (cfg_err !== merr) begin
          n_bad++; $display("FAIL cfg_err t=%0d got %b exp %b", tcyc, cfg_err, merr);
        end
        for (int c = 0; c < CH; c++) if (coil_out[c] && !prev_coil[c]) n_rise[c]++;
        if (coil_out[2]) hi2++;
        prev_coil = coil_out;
        acnt_ena = 0; cfg_we = 0; fault_clr = '0;
        if (rnd) hwag_start = 1;
      end
    end
  endtask

  task automatic clr_counts();
    for (int c = 0; c < CH; c++) n_rise[c] = 0;
    hi2 = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; hwag_start = 0; acnt_ena = 0; acnt = '0; cfg_we = 0; cfg_ch = '0;
    cfg_charge = '0; cfg_ignite = '0; max_dwell = '0; fault_clr = '0; sw_en = 0;
    prev_coil = '0;
    model_reset();
    repeat (3) cyc();
    n_cmp += 4;
    if (coil_out !== 4'b0)  begin n_bad++; $display("FAIL reset_coil got %b exp 0000", coil_out); end
    if (ch_fault !== 4'b0)  begin n_bad++; $display("FAIL reset_fault got %b exp 0000", ch_fault); end
    if (cfg_ack !== 1'b0)   begin n_bad++; $display("FAIL reset_ack got %b exp 0", cfg_ack); end
    if (cfg_err !== 1'b0)   begin n_bad++; $display("FAIL reset_err got %b exp 0", cfg_err); end
    rst_n = 1;
    cyc();
  endtask

  task automatic test_cfg_accept();
    wr_cfg(0, 100, 200);
    n_cmp += 2;
    if (cfg_ack !== 1'b1) begin n_bad++; $display("FAIL cfg0_ack got %b exp 1", cfg_ack); end
    if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL cfg0_err got %b exp 0", cfg_err); end
    wr_cfg(1, 3800, 50);
    n_cmp++;
    if (cfg_ack !== 1'b1) begin n_bad++; $display("FAIL cfg1_ack got %b exp 1", cfg_ack); end
    cyc();
    n_cmp++;
    if (cfg_ack !== 1'b0) begin n_bad++; $display("FAIL ack_pulse got %b exp 0", cfg_ack); end
    repeat (3) cyc();
  endtask

  task automatic test_revolution();
    hwag_start = 1; max_dwell = '0;
    clr_counts();
    sweep(0, 3839, 4, 0);
    n_cmp += 2;
    if (n_rise[0] != 1) begin n_bad++; $display("FAIL rev_rises ch0 got %0d exp 1", n_rise[0]); end
    if (coil_out[1] !== 1'b1) begin n_bad++; $display("FAIL wrap_hold ch1 got %b exp 1", coil_out[1]); end
  endtask

  task automatic test_update_mid_charge();
    clr_counts();
    sw_en = 1; sw_at = 150; sw_ch = 0; sw_c = 500; sw_i = 600;
    sweep(0, 400, 4, 0);
    n_cmp += 3;
    if (n_rise[0] != 1) begin n_bad++; $display("FAIL upd_rises ch0 got %0d exp 1", n_rise[0]); end
    if (coil_out[0] !== 1'b0) begin n_bad++; $display("FAIL upd_end ch0 got %b exp 0", coil_out[0]); end
    if (coil_out[1] !== 1'b0) begin n_bad++; $display("FAIL wrap_end ch1 got %b exp 0", coil_out[1]); end
  endtask

  task automatic test_dwell();
    max_dwell = 24'd40;
    wr_cfg(2, 100, 200);
    repeat (3) cyc();
    clr_counts();
    sweep(0, 700, 4, 0);
    n_cmp += 3;
    if (hi2 != 40) begin n_bad++; $display("FAIL dwell_len ch2 got %0d exp 40", hi2); end
    if (ch_fault[2] !== 1'b1) begin n_bad++; $display("FAIL dwell_fault ch2 got %b exp 1", ch_fault[2]); end
    if (n_rise[0] != 1) begin n_bad++; $display("FAIL new_window ch0 rises got %0d exp 1", n_rise[0]); end
    clr_counts();
    sweep(0, 700, 4, 0);
    n_cmp += 2;
    if (hi2 != 40) begin n_bad++; $display("FAIL dwell_len2 ch2 got %0d exp 40", hi2); end
    if (ch_fault[2] !== 1'b1) begin n_bad++; $display("FAIL fault_sticky ch2 got %b exp 1", ch_fault[2]); end
    fault_clr = 4'b0100;
    cyc();
    fault_clr = '0;
    n_cmp += 2;
    if (ch_fault[2] !== 1'b0) begin n_bad++; $display("FAIL fault_clr ch2 got %b exp 0", ch_fault[2]); end
    if (ch_fault !== exp_fault()) begin n_bad++; $display("FAIL fault_clr_other got %b exp %b", ch_fault, exp_fault()); end
  endtask

  task automatic test_cfg_reject();
    wr_cfg(0, 3840, 10);
    n_cmp += 2;
    if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL err_range got %b exp 1", cfg_err); end
    if (cfg_ack !== 1'b0) begin n_bad++; $display("FAIL err_range_ack got %b exp 0", cfg_ack); end
    wr_cfg(1, 300, 300);
    n_cmp++;
    if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL err_equal got %b exp 1", cfg_err); end
    wr_cfg(3, 3839, 0);
    n_cmp += 2;
    if (cfg_ack !== 1'b1) begin n_bad++; $display("FAIL ack_top got %b exp 1", cfg_ack); end
    if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL ack_top_err got %b exp 0", cfg_err); end
    repeat (3) cyc();
  endtask

  task automatic test_hwag_drop();
    max_dwell = '0;
    sweep(0, 150, 4, 0);
    n_cmp++;
    if (coil_out[2] !== 1'b1) begin n_bad++; $display("FAIL pre_drop ch2 got %b exp 1", coil_out[2]); end
    hwag_start = 0;
    cyc();
    n_cmp += 2;
    if (coil_out !== 4'b0) begin n_bad++; $display("FAIL drop_coil got %b exp 0000", coil_out); end
    if (ch_fault !== exp_fault()) begin n_bad++; $display("FAIL drop_fault got %b exp %b", ch_fault, exp_fault()); end
    hwag_start = 1;
    cyc();
  endtask

  task automatic test_async_reset();
    sweep(0, 150, 4, 0);
    n_cmp++;
    if (coil_out[2] !== 1'b1) begin n_bad++; $display("FAIL pre_rst ch2 got %b exp 1", coil_out[2]); end
    #2 rst_n = 0;
    #1;
    model_reset();
    n_cmp += 2;
    if (coil_out !== 4'b0) begin n_bad++; $display("FAIL async_rst_coil got %b exp 0000", coil_out); end
    if (ch_fault !== 4'b0) begin n_bad++; $display("FAIL async_rst_fault got %b exp 0000", ch_fault); end
    repeat (2) cyc();
    rst_n = 1;
    cyc();
  endtask

  task automatic test_random();
    max_dwell = 24'($urandom_range(8, 120));
    hwag_start = 1;
    sweep(0, 3839, 0, 1);
    max_dwell = 24'($urandom_range(1, 6));
    sweep(0, 1500, 0, 1);
  endtask

  initial begin
    test_reset();
    test_cfg_accept();
    test_revolution();
    test_update_mid_charge();
    test_dwell();
    test_cfg_reject();
    test_hwag_drop();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hwag_coil_sched.md
# hwag_coil_sched

Per-channel ignition coil scheduler for the HWAG angle generator. Holds per-channel charge/ignition angles and sequences each coil output against the shared angle counter (ACNT value plus its advance strobe). Applies CPU-side angle updates only at safe points and enforces a maximum dwell time. Sits between the HWAG core angle outputs and the coil driver pins.

## Interface
- CH, 4, number of coil channels
- AW, 24, angle width (matches ACNT)
- DW, 24, dwell timeout counter width (clk cycles)
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- hwag_start  in  1  HWAG synchronised; low = no valid angle
- acnt_ena  in  1  one-cycle strobe: acnt advanced this cycle
- acnt  in  AW  current angle, 0..ACNT_TOP (3839)
- cfg_we  in  1  config write strobe
- cfg_ch  in  $clog2(CH)  target channel
- cfg_charge  in  AW  charge-start angle
- cfg_ignite  in  AW  ignition angle
- cfg_ack  out  1  write accepted (1-cycle pulse)
- cfg_err  out  1  write rejected (1-cycle pulse)
- max_dwell  in  DW  dwell limit in clk cycles; 0 disables the limit
- coil_out  out  CH  coil drive; 1 = charging
- ch_fault  out  CH  sticky dwell-timeout flag per channel
- fault_clr  in  CH  clears the matching ch_fault bits

## Operation
- Per channel: a pending register (charge, ignite, valid) and an active register (charge, ignite).
- Config write:
  - Accepted when cfg_charge ≤ 3839, cfg_ignite ≤ 3839 and cfg_charge ≠ cfg_ignite: load pending, set valid, cfg_ack.
  - Otherwise: pending unchanged, cfg_err.
  - A second write before commit overwrites pending.
- Commit: pending is copied to active, and valid cleared, in any cycle where the channel is IDLE and no charge match is occurring in that cycle.
- Channel FSM:
  - IDLE:
    - Entry requires hwag_start=1 and acnt_ena=1 and acnt == active.charge → CHARGE.
    - Clear the dwell counter on entry to CHARGE.
  - CHARGE:
    - Dwell counter increments every clk, saturating.
    - acnt_ena and acnt == active.ignite → IDLE (normal spark).
    - Else max_dwell≠0 and dwell counter == max_dwell−1 → FIRED, set ch_fault.
  - FIRED: coil off; return to IDLE on the next acnt_ena where acnt == active.ignite. This prevents re-charging in the same cycle.
  - hwag_start=0 in any state → IDLE next cycle, coil off. ch_fault is not set.
- coil_out = (state == CHARGE), registered.
- Wrap-around: angles are modular over 0..3839. A charge window crossing ACNT_TOP (e.g. charge 3800, ignite 100) works unchanged because only equality matches are used.
- If charge and ignite match simultaneously, the FSM ignores it; this is impossible by config check, but the active register holds previously validated values only.
- Reset: all FSMs IDLE. Active and pending registers = 0 with valid=0. Channels with active charge==ignite==0 never leave IDLE. coil_out=0, ch_fault=0, cfg_ack=0, cfg_err=0.
- fault_clr and a timeout on the same channel in the same cycle: set wins.

## Timing
- cfg_ack/cfg_err assert the cycle after the cfg_we cycle.
- Earliest commit: the cycle after ack, given IDLE.
- coil_out rises 1 clk after the acnt_ena cycle matching charge.
- coil_out falls 1 clk after the acnt_ena cycle matching ignite.
- Timeout: coil_out falls after exactly max_dwell clk cycles high. ch_fault rises in the same cycle as that fall.
- hwag_start fall: coil_out low 1 clk later.
- No combinational path from inputs to outputs.

## Structure
- Shared package hwag_pkg:
  - ACNT_TOP = 24'd3839
  - coil_state_t enum {IDLE, CHARGE, FIRED}
  - angle_t (logic [23:0])
- Sub-module hwag_coil_channel: one FSM, dwell counter, pending/active registers, commit logic. Instantiated CH times by generate.
- The top level holds config decode, ack/err generation and the fault_clr fan-out.

## Test plan
- Write ch0 charge=100, ignite=200, sweep acnt 0..3839 with acnt_ena every 4 clk, max_dwell=0 → cfg_ack; coil_out[0] rises 1 clk after acnt=100 strobe, falls 1 clk after acnt=200 strobe, once per revolution.
- ch1 charge=3800, ignite=50 → coil_out[1] high across the 3839→0 wrap, low after acnt=50.
- ch2 charge=100, ignite=200, max_dwell=40, acnt_ena every 4 clk → coil_out[2] high exactly 40 clk. ch_fault[2]=1 and stays through the next revolution. No re-charge until acnt=200 has passed; fault_clr[2] clears it.
- While ch0 in CHARGE, write ch0 charge=500, ignite=600 → current cycle still ends at 200; next revolution uses 500/600.
- Write cfg_charge=3840, then a write with charge=ignite=300 → cfg_err both times, schedule unchanged.
- Drop hwag_start mid-CHARGE, then assert rst low mid-CHARGE → coil_out low 1 clk later with ch_fault unchanged; on reset, all outputs 0 asynchronously.
